// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - registered ID-stage control unit with CALL/RET/RTI/interrupt micro-sequencing
module control_sequencer #(
  parameter int PC_SLOTS = 2,
  parameter int FUNC_W   = 3,
  parameter int SLOT_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        opcode,
  input  logic              instr_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              int_req,
  output logic              wb_cntrl,
  output logic [3:0]        me_cntrl,
  output logic [FUNC_W:0]   ex_cntrl,
  output logic [6:0]        instr_id_srcs,
  output logic [SLOT_W-1:0] slot,
  output logic              pc_load,
  output logic              flag_save,
  output logic              flag_restore,
  output logic              vec_sel,
  output logic              int_ack,
  output logic              hold
);

  localparam logic [6:0]        OP_CALL   = 7'b1110000;
  localparam logic [6:0]        OP_RET    = 7'b1110001;
  localparam logic [6:0]        OP_RTI    = 7'b1110010;
  localparam logic [3:0]        ME_NOP    = 4'b0001;
  localparam logic [3:0]        ME_PUSH   = 4'b1010;
  localparam logic [3:0]        ME_POP    = 4'b0100;
  localparam logic [FUNC_W:0]   EX_NOP    = {{FUNC_W{1'b0}}, 1'b1};
  localparam logic [6:0]        SRC_JMP   = 7'b1000000;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PC_SLOTS - 1);

  typedef enum logic [2:0] {IDLE, PUSHF, PUSHPC, POPPC, POPF, JUMP} state_t;

  state_t            state;
  logic              is_rti;
  logic              is_int;
  logic [SLOT_W-1:0] slot_inc;
  logic              seq_done;

  logic              dec_wb;
  logic [3:0]        dec_me;
  logic [FUNC_W:0]   dec_ex;
  logic [6:0]        dec_srcs;

  // state names the micro-op currently on the outputs; seq_done marks the
  // last one, so the following edge decodes a fresh instruction
  assign slot_inc = slot + SLOT_W'(1);
  assign seq_done = (state == IDLE) || (state == JUMP) || (state == POPF) ||
                    ((state == POPPC) && (slot == LAST_SLOT) && !is_rti);

  always_comb begin
    dec_wb   = 1'b1;
    dec_me   = ME_NOP;
    dec_ex   = EX_NOP;
    dec_srcs = 7'b0;
    if (instr_valid) begin
      casez (opcode)
        7'b0001100: dec_srcs[3] = 1'b1;
        7'b010????: begin
          dec_ex      = {FUNC_W'(opcode[2:0]), 1'b0};
          dec_wb      = 1'b0;
          dec_srcs[1] = opcode[3];
        end
        7'b011?000: begin
          dec_wb      = 1'b0;
          dec_srcs[0] = opcode[3];
        end
        7'b100?000: begin
          dec_me      = {~opcode[3], opcode[3], ~opcode[3], 1'b0};
          dec_wb      = ~opcode[3];
          dec_srcs[1] = opcode[3];
        end
        7'b101?000: begin
          dec_ex[0]   = 1'b0;
          dec_me      = {opcode[3], 3'b000};
          dec_wb      = opcode[3];
          dec_srcs[1] = 1'b1;
          dec_srcs[2] = ~opcode[3];
        end
        7'b110????: begin
          case (opcode[3:2])
            2'b00:   dec_srcs[6:4] = 3'b101;
            2'b01:   dec_srcs[6:4] = 3'b110;
            2'b10:   dec_srcs[6:4] = 3'b111;
            default: dec_srcs[6:4] = 3'b100;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state         <= IDLE;
      is_rti        <= 1'b0;
      is_int        <= 1'b0;
      wb_cntrl      <= 1'b1;
      me_cntrl      <= ME_NOP;
      ex_cntrl      <= EX_NOP;
      instr_id_srcs <= 7'b0;
      slot          <= '0;
      pc_load       <= 1'b0;
      flag_save     <= 1'b0;
      flag_restore  <= 1'b0;
      vec_sel       <= 1'b0;
      int_ack       <= 1'b0;
      hold          <= 1'b0;
    end else if (!stall) begin
      wb_cntrl      <= 1'b1;
      me_cntrl      <= ME_NOP;
      ex_cntrl      <= EX_NOP;
      instr_id_srcs <= 7'b0;
      slot          <= '0;
      pc_load       <= 1'b0;
      flag_save     <= 1'b0;
      flag_restore  <= 1'b0;
      vec_sel       <= 1'b0;
      int_ack       <= 1'b0;
      hold          <= 1'b1;
      if (seq_done) begin
        // interrupt wins over the ID instruction, which stays put for replay
        if (int_req) begin
          state     <= PUSHF;
          is_int    <= 1'b1;
          is_rti    <= 1'b0;
          me_cntrl  <= ME_PUSH;
          flag_save <= 1'b1;
          int_ack   <= 1'b1;
        end else if (instr_valid && opcode == OP_CALL) begin
          state    <= PUSHPC;
          is_int   <= 1'b0;
          slot     <= LAST_SLOT;
          me_cntrl <= ME_PUSH;
        end else if (instr_valid && (opcode == OP_RET || opcode == OP_RTI)) begin
          state    <= POPPC;
          is_rti   <= (opcode == OP_RTI);
          me_cntrl <= ME_POP;
          pc_load  <= (PC_SLOTS == 1);
        end else begin
          state         <= IDLE;
          hold          <= 1'b0;
          wb_cntrl      <= dec_wb;
          me_cntrl      <= dec_me;
          ex_cntrl      <= dec_ex;
          instr_id_srcs <= dec_srcs;
        end
      end else begin
        case (state)
          PUSHF: begin
            state    <= PUSHPC;
            slot     <= LAST_SLOT;
            me_cntrl <= ME_PUSH;
          end
          PUSHPC: begin
            if (slot == '0) begin
              state         <= JUMP;
              instr_id_srcs <= SRC_JMP;
              vec_sel       <= is_int;
            end else begin
              slot     <= slot - SLOT_W'(1);
              me_cntrl <= ME_PUSH;
            end
          end
          POPPC: begin
            me_cntrl <= ME_POP;
            if (slot == LAST_SLOT) begin
              state        <= POPF;
              flag_restore <= 1'b1;
            end else begin
              slot    <= slot_inc;
              pc_load <= (slot_inc == LAST_SLOT);
            end
          end
          default: begin
            state <= IDLE;
            hold  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized bench for control_sequencer against a micro-op queue model
module tb_control_sequencer;

  localparam int PCS = 3;
  localparam int FW  = 3;
  localparam int SW  = 3;

  localparam logic [6:0] OP_CALL = 7'b1110000;
  localparam logic [6:0] OP_RET  = 7'b1110001;
  localparam logic [6:0] OP_RTI  = 7'b1110010;
  localparam logic [6:0] OP_ADD  = 7'b0100000;
  localparam logic [6:0] OP_ADDI = 7'b0101000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, instr_valid, stall, flush, int_req;
  logic [6:0]    opcode;
  logic          wb_cntrl;
  logic [3:0]    me_cntrl;
  logic [FW:0]   ex_cntrl;
  logic [6:0]    instr_id_srcs;
  logic [SW-1:0] slot;
  logic          pc_load, flag_save, flag_restore, vec_sel, int_ack, hold;

  control_sequencer #(.PC_SLOTS(PCS), .FUNC_W(FW), .SLOT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .int_req(int_req),
    .wb_cntrl(wb_cntrl), .me_cntrl(me_cntrl), .ex_cntrl(ex_cntrl),
    .instr_id_srcs(instr_id_srcs), .slot(slot), .pc_load(pc_load),
    .flag_save(flag_save), .flag_restore(flag_restore), .vec_sel(vec_sel),
    .int_ack(int_ack), .hold(hold)
  );

  typedef struct packed {
    logic          wb;
    logic [3:0]    me;
    logic [FW:0]   ex;
    logic [6:0]    srcs;
    logic [SW-1:0] slot;
    logic          pc_load;
    logic          flag_save;
    logic          flag_restore;
    logic          vec_sel;
    logic          int_ack;
    logic          hold;
  } bundle_t;

  bundle_t dut_b;
  bundle_t exp_b;
  bundle_t seq_q[$];
  int      vectors = 0;
  int      miscompares = 0;

  assign dut_b = {wb_cntrl, me_cntrl, ex_cntrl, instr_id_srcs, slot,
                  pc_load, flag_save, flag_restore, vec_sel, int_ack, hold};

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic bundle_t nop_b();
    bundle_t b = '0;
    b.wb    = 1'b1;
    b.me    = 4'b0001;
    b.ex[0] = 1'b1;
    return b;
  endfunction

  function automatic bundle_t mem_b(input bit is_push, input int s);
    bundle_t b = nop_b();
    b.me   = is_push ? 4'b1010 : 4'b0100;
    b.slot = SW'(s);
    b.hold = 1'b1;
    return b;
  endfunction

  function automatic bundle_t decode_b(input logic [6:0] op);
    bundle_t    b   = nop_b();
    logic [2:0] grp = op[6:4];
    logic       m   = op[3];
    if (op == 7'b0001100) b.srcs[3] = 1'b1;
    else if (grp == 3'b010) begin
      b.ex = {FW'(op[2:0]), 1'b0};
      b.wb = 1'b0;
      b.srcs[1] = m;
    end else if (grp == 3'b011 && op[2:0] == 3'b000) begin
      b.wb = 1'b0;
      b.srcs[0] = m;
    end else if (grp == 3'b100 && op[2:0] == 3'b000) begin
      if (m) begin b.me = 4'b0100; b.wb = 1'b0; b.srcs[1] = 1'b1; end
      else b.me = 4'b1010;
    end else if (grp == 3'b101 && op[2:0] == 3'b000) begin
      b.ex[0] = 1'b0;
      b.srcs[1] = 1'b1;
      if (m) b.me = 4'b1000;
      else begin b.me = 4'b0000; b.wb = 1'b0; b.srcs[2] = 1'b1; end
    end else if (grp == 3'b110) begin
      case (op[3:2])
        2'd0:    b.srcs[6:4] = 3'b101;
        2'd1:    b.srcs[6:4] = 3'b110;
        2'd2:    b.srcs[6:4] = 3'b111;
        default: b.srcs[6:4] = 3'b100;
      endcase
    end
    return b;
  endfunction

  task automatic queue_pc_pushes_and_jump(input bit vec);
    bundle_t b;
    for (int i = PCS - 1; i >= 0; i--) seq_q.push_back(mem_b(1'b1, i));
    b = nop_b();
    b.srcs = 7'b1000000;
    b.vec_sel = vec;
    b.hold = 1'b1;
    seq_q.push_back(b);
  endtask

  task automatic queue_pc_pops(input bit with_flags);
    bundle_t b;
    for (int i = 0; i < PCS; i++) begin
      b = mem_b(1'b0, i);
      b.pc_load = (i == PCS - 1);
      seq_q.push_back(b);
    end
    if (with_flags) begin
      b = mem_b(1'b0, 0);
      b.flag_restore = 1'b1;
      seq_q.push_back(b);
    end
  endtask

  // one clock edge of the reference: sequences are pre-expanded into a list of bundles
  task automatic model_edge();
    bundle_t b;
    if (!rst_n || flush) begin
      exp_b = nop_b();
      seq_q.delete();
    end else if (stall) begin
    end else if (seq_q.size() > 0) begin
      exp_b = seq_q.pop_front();
    end else begin
      if (int_req) begin
        b = mem_b(1'b1, 0);
        b.flag_save = 1'b1;
        b.int_ack = 1'b1;
        seq_q.push_back(b);
        queue_pc_pushes_and_jump(1'b1);
      end else if (instr_valid && opcode == OP_CALL) queue_pc_pushes_and_jump(1'b0);
      else if (instr_valid && opcode == OP_RET) queue_pc_pops(1'b0);
      else if (instr_valid && opcode == OP_RTI) queue_pc_pops(1'b1);
      if (seq_q.size() > 0) exp_b = seq_q.pop_front();
      else exp_b = instr_valid ? decode_b(opcode) : nop_b();
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_vec(tag, 32'(dut_b), 32'(exp_b));
  endtask

  logic [6:0] ops [18] = '{7'b0001100, 7'b0010100, 7'b0101000, 7'b0100001, 7'b0100111,
                          7'b0110000, 7'b0111000, 7'b1000000, 7'b1001000, 7'b1010000,
                          7'b1011000, 7'b1100000, 7'b1100100, 7'b1101000, 7'b1101100,
                          OP_CALL, OP_RET, OP_RTI};

  initial begin
    exp_b = nop_b();
    rst_n = 1'b0; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0; int_req = 1'b0;
    opcode = 7'b0;
    step("reset0");
    step("reset1");

    rst_n = 1'b1; instr_valid = 1'b1; opcode = OP_ADDI;
    step("addi");
    check_vec("addi_fields", {ex_cntrl, wb_cntrl, instr_id_srcs, me_cntrl},
              {4'b0000, 1'b0, 7'b0000010, 4'b0001});

    opcode = OP_CALL;
    step("call_push_hi");
    opcode = OP_ADD;
    for (int i = 0; i < PCS; i++) step("call_seq");
    step("call_next_add");

    opcode = OP_RTI;
    step("rti_pop0");
    instr_valid = 1'b0;
    for (int i = 0; i < PCS; i++) step("rti_seq");
    step("rti_after");

    instr_valid = 1'b1; opcode = OP_ADD; int_req = 1'b1;
    step("int_ack");
    int_req = 1'b0;
    for (int i = 0; i < PCS + 1; i++) step("int_seq");
    step("int_replay_add");

    opcode = OP_CALL;
    step("stall_call0");
    opcode = OP_ADD;
    step("stall_call1");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step("stall_hold");
    stall = 1'b0;
    for (int i = 0; i < 3; i++) step("stall_resume");

    opcode = OP_RET;
    step("ret_pop0");
    flush = 1'b1;
    step("ret_flush");
    flush = 1'b0; instr_valid = 1'b0;
    step("post_flush");

    instr_valid = 1'b1; opcode = OP_CALL;
    step("rst_call0");
    step("rst_call1");
    rst_n = 1'b0;
    step("rst_mid_call");
    rst_n = 1'b1; instr_valid = 1'b0;
    step("rst_after");

    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      stall       = ($urandom_range(0, 6) == 0);
      flush       = ($urandom_range(0, 24) == 0);
      int_req     = ($urandom_range(0, 19) == 0);
      instr_valid = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) opcode = 7'($urandom);
      else opcode = ops[$urandom_range(0, 17)];
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
